pipe_skid_reg: RTL

- Parametrised pipeline-stage register, the next generation of the IF/ID latch, usable for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries an arbitrary-width payload with a valid/ready handshake, so stalls propagate backward without losing data.
- Supports a synchronous flush that injects a NOP bubble.
- Optional two-entry skid buffer: In_Ready is registered and breaks the combinational ready path between stages.

---
 rtl/pipe_pkg.sv | 24 ++
 rtl/pipe_skid_reg.sv | 137 +++++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline-stage registers.
// The state encoding is {skid_valid, main_valid}.
package pipe_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    localparam logic [1:0] ST_EMPTY = 2'b00;
    localparam logic [1:0] ST_ONE   = 2'b01;
    localparam logic [1:0] ST_FULL  = 2'b11;

    typedef enum logic [1:0] {
        S_EMPTY = ST_EMPTY,
        S_ONE   = ST_ONE,
        S_FULL  = ST_FULL
    } stage_state_e;

    function automatic logic [1:0] occupancy_of(input logic main_v, input logic skid_v);
        return {1'b0, main_v} + {1'b0, skid_v};
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Valid/ready pipeline-stage register with flush-to-NOP and an optional
// two-entry skid buffer that registers In_Ready.
module pipe_skid_reg
    import pipe_pkg::*;
#(
    parameter int unsigned       DATA_W    = PC_W + INSTR_W,
    parameter logic [DATA_W-1:0] NOP_VALUE = {DATA_W{1'b0}},
    parameter int unsigned       SKID      = 1
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [DATA_W-1:0] In_Data,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Out_Data,
    output logic [1:0]        Occupancy
);

    generate
        if (SKID != 0) begin : g_skid
            stage_state_e      state_q, state_d;
            logic [DATA_W-1:0] main_q, main_d;
            logic [DATA_W-1:0] skid_q, skid_d;
            logic              in_ready_q, in_ready_d;
            logic              main_valid, skid_valid;
            logic              push, pop;

            assign main_valid = (state_q != S_EMPTY);
            assign skid_valid = (state_q == S_FULL);
            assign push       = In_Valid & in_ready_q;
            assign pop        = main_valid & Out_Ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                if (Flush) begin
                    state_d = S_EMPTY;
                end else begin
                    case (state_q)
                        S_EMPTY: begin
                            if (push) begin
                                main_d  = In_Data;
                                state_d = S_ONE;
                            end
                        end
                        S_ONE: begin
                            if (push && pop) begin
                                main_d = In_Data;
                            end else if (push) begin
                                skid_d  = In_Data;
                                state_d = S_FULL;
                            end else if (pop) begin
                                state_d = S_EMPTY;
                            end
                        end
                        S_FULL: begin
                            if (pop) begin
                                main_d  = skid_q;
                                state_d = S_ONE;
                            end
                        end
                        default: state_d = S_EMPTY;
                    endcase
                end
                // Ready is decided from the next state so it is a clean flop output.
                in_ready_d = (state_d != S_FULL);
            end

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    state_q    <= S_EMPTY;
                    main_q     <= NOP_VALUE;
                    skid_q     <= NOP_VALUE;
                    in_ready_q <= 1'b0;
                end else begin
                    state_q    <= state_d;
                    main_q     <= main_d;
                    skid_q     <= skid_d;
                    in_ready_q <= in_ready_d;
                end
            end

            assign In_Ready  = in_ready_q;
            assign Out_Valid = main_valid;
            assign Out_Data  = main_valid ? main_q : NOP_VALUE;
            assign Occupancy = occupancy_of(main_valid, skid_valid);
        end else begin : g_single
            stage_state_e      state_q, state_d;
            logic [DATA_W-1:0] main_q, main_d;
            logic              started_q;
            logic              main_valid;
            logic              in_ready;
            logic              push, pop;

            assign main_valid = (state_q == S_ONE);
            // started_q holds ready low until the first edge after reset release.
            assign in_ready   = started_q & (~main_valid | Out_Ready);
            assign push       = In_Valid & in_ready;
            assign pop        = main_valid & Out_Ready;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                if (Flush) begin
                    state_d = S_EMPTY;
                end else if (push) begin
                    main_d  = In_Data;
                    state_d = S_ONE;
                end else if (pop) begin
                    state_d = S_EMPTY;
                end
            end

            always_ff @(posedge Clk or negedge Rst_n) begin
                if (!Rst_n) begin
                    state_q   <= S_EMPTY;
                    main_q    <= NOP_VALUE;
                    started_q <= 1'b0;
                end else begin
                    state_q   <= state_d;
                    main_q    <= main_d;
                    started_q <= 1'b1;
                end
            end

            assign In_Ready  = in_ready;
            assign Out_Valid = main_valid;
            assign Out_Data  = main_valid ? main_q : NOP_VALUE;
            assign Occupancy = occupancy_of(main_valid, 1'b0);
        end
    endgenerate

endmodule
